cp0: RTL and testbench

CP0 -- requirements
Module: cp0

---
 rtl/cp0_pkg.sv | 35 +++
 rtl/cp0.sv | 150 +++++++++++++++
 tb/tb_cp0.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, ExcCode values
// and the EXL-based state encoding.
package cp0_pkg;

  // CP0 register numbers addressed by sel
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR field positions
  localparam int unsigned SR_IE     = 0;
  localparam int unsigned SR_EXL    = 1;
  localparam int unsigned SR_IM_LSB = 10;

  // Cause field positions
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_EXC_W   = 5;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_BD      = 31;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // NORMAL is EXL=0, HANDLER is EXL=1
  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } cp0_state_e;

endpackage

// File: rtl/cp0.sv
// CP0: SR / Cause / EPC / PRId registers, interrupt request generation and
// exception entry / eret control for a MIPS-style pipeline.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   hw_int           level hardware interrupt lines (sampled into Cause.IP)
//   sel, we, wd      register select, mtc0 strobe and data
//   rd               mfc0 read data (combinational from sel, registered state)
//   pc, bd           PC and delay-slot flag of the exception-stage instruction
//   exc_valid        synchronous exception present, exc_code its ExcCode
//   eret             eret executing this cycle
//   int_req          interrupt pending and enabled (combinational from regs)
//   exc_enter        entry accepted this cycle
//   epc_out          current EPC, eret target
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_2333,
  parameter int unsigned HW_INT_W   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic [4:0]          sel,
  input  logic                we,
  input  logic [31:0]         wd,
  output logic [31:0]         rd,
  input  logic [31:0]         pc,
  input  logic                bd,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic                eret,
  output logic                int_req,
  output logic                exc_enter,
  output logic [31:0]         epc_out
);

  cp0_state_e          r_state;
  cp0_state_e          w_state_nxt;
  logic [HW_INT_W-1:0] r_im;
  logic                r_ie;
  logic [HW_INT_W-1:0] r_ip;
  logic                r_bd;
  logic [4:0]          r_exccode;
  logic [31:0]         r_epc;

  logic                w_wr_sr;
  logic                w_wr_epc;
  logic [31:0]         w_pc_aligned;
  logic [31:0]         w_entry_epc;
  logic [31:0]         w_sr;
  logic [31:0]         w_cause;

  assign w_wr_sr      = we && (sel == REG_SR);
  assign w_wr_epc     = we && (sel == REG_EPC);
  assign w_pc_aligned = pc & ~32'd3;
  // Delay-slot instructions restart at the branch, one word earlier
  assign w_entry_epc  = bd ? (w_pc_aligned - 32'd4) : w_pc_aligned;
  assign epc_out      = r_epc;

  // EXL state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Interrupt request, entry and EXL next state; entry > eret > mtc0 to SR
  always_comb begin
    w_state_nxt = r_state;
    int_req     = 1'b0;
    exc_enter   = 1'b0;

    if (r_state == ST_NORMAL) begin
      int_req = (|(r_ip & r_im)) & r_ie;
    end
    exc_enter = int_req | exc_valid;

    case (r_state)
      ST_NORMAL: begin
        if (exc_enter) begin
          w_state_nxt = ST_HANDLER;
        end else if (eret) begin
          w_state_nxt = ST_NORMAL;
        end else if (w_wr_sr && wd[SR_EXL]) begin
          w_state_nxt = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (exc_enter) begin
          w_state_nxt = ST_HANDLER;
        end else if (eret) begin
          w_state_nxt = ST_NORMAL;
        end else if (w_wr_sr && !wd[SR_EXL]) begin
          w_state_nxt = ST_NORMAL;
        end
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  // SR, Cause and EPC fields; entry fields take priority over mtc0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im      <= '0;
      r_ie      <= 1'b0;
      r_ip      <= '0;
      r_bd      <= 1'b0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= hw_int;
      if (w_wr_sr) begin
        r_im <= wd[SR_IM_LSB +: HW_INT_W];
        r_ie <= wd[SR_IE];
      end
      if (exc_enter) begin
        r_epc     <= w_entry_epc;
        r_bd      <= bd;
        r_exccode <= int_req ? EXC_INT : exc_code;
      end else if (w_wr_epc) begin
        r_epc <= wd & ~32'd3;
      end
    end
  end

  // Assemble architectural register images and mfc0 mux
  always_comb begin
    w_sr                                 = '0;
    w_sr[SR_IE]                          = r_ie;
    w_sr[SR_EXL]                         = (r_state == ST_HANDLER);
    w_sr[SR_IM_LSB +: HW_INT_W]          = r_im;

    w_cause                              = '0;
    w_cause[CAUSE_BD]                    = r_bd;
    w_cause[CAUSE_IP_LSB +: HW_INT_W]    = r_ip;
    w_cause[CAUSE_EXC_LSB +: CAUSE_EXC_W] = r_exccode;

    rd = '0;
    case (sel)
      REG_SR:    rd = w_sr;
      REG_CAUSE: rd = w_cause;
      REG_EPC:   rd = r_epc;
      REG_PRID:  rd = PRID_VALUE;
      default:   rd = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Bench for cp0: directed vector table, async reset sequence, then random
// stimulus checked against a register-image reference model.
module tb_cp0;

  localparam logic [31:0] PRID = 32'h0000_2333;
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

  logic        clk;
  logic        reset;
  logic [5:0]  hw_int;
  logic [4:0]  sel;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [31:0] pc;
  logic        bd;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        eret;
  logic        int_req;
  logic        exc_enter;
  logic [31:0] epc_out;

  cp0 #(.PRID_VALUE(PRID), .HW_INT_W(6)) dut (
    .clk(clk), .reset(reset), .hw_int(hw_int), .sel(sel), .we(we), .wd(wd),
    .rd(rd), .pc(pc), .bd(bd), .exc_valid(exc_valid), .exc_code(exc_code),
    .eret(eret), .int_req(int_req), .exc_enter(exc_enter), .epc_out(epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic        we;
    logic [4:0]  sel;
    logic [31:0] wd;
    logic [5:0]  hw;
    logic [31:0] pc;
    logic        bd;
    logic        ev;
    logic [4:0]  code;
    logic        eret;
    logic        x_int;
    logic        x_ent;
    logic [31:0] x_rd;
    logic [31:0] x_epc;
  } vec_t;

  vec_t tbl[25];

  // Reference model: whole architectural register images
  logic [31:0] m_sr, m_cause, m_epc;
  logic [31:0] n_sr, n_cause, n_epc;

  function automatic vec_t mk(logic w, logic [4:0] s, logic [31:0] d, logic [5:0] h,
                              logic [31:0] p, logic b, logic e, logic [4:0] c, logic r,
                              logic xi, logic xe, logic [31:0] xr, logic [31:0] xp);
    vec_t v;
    v.we = w; v.sel = s; v.wd = d; v.hw = h; v.pc = p; v.bd = b; v.ev = e;
    v.code = c; v.eret = r; v.x_int = xi; v.x_ent = xe; v.x_rd = xr; v.x_epc = xp;
    return v;
  endfunction

  function automatic logic m_int();
    return (|(m_cause[15:10] & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
  endfunction

  function automatic logic [31:0] m_rd(logic [4:0] s);
    case (s)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t v);
    we = v.we; sel = v.sel; wd = v.wd; hw_int = v.hw; pc = v.pc; bd = v.bd;
    exc_valid = v.ev; exc_code = v.code; eret = v.eret;
  endtask

  // Next model state from current state and this cycle's inputs
  task automatic model_next(input vec_t v);
    logic ent, irq;
    irq = m_int();
    ent = irq | v.ev;
    n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
    if (v.we && v.sel == 5'd12) n_sr = v.wd & SR_WMASK;
    if (v.we && v.sel == 5'd14) n_epc = v.wd & 32'hFFFF_FFFC;
    if (v.eret) n_sr[1] = 1'b0;
    n_cause[15:10] = v.hw;
    if (ent) begin
      n_sr[1] = 1'b1;
      n_epc = (v.pc & 32'hFFFF_FFFC) - (v.bd ? 32'd4 : 32'd0);
      n_cause[31] = v.bd;
      n_cause[6:2] = irq ? 5'd0 : v.code;
    end
  endtask

  // One clock: drive, check at negedge, advance model at posedge
  task automatic run_cycle(input vec_t v, input logic use_tbl, input string tag);
    drive(v);
    @(negedge clk);
    if (use_tbl) begin
      chk({tag, " int_req"}, 32'(int_req), 32'(v.x_int));
      chk({tag, " exc_enter"}, 32'(exc_enter), 32'(v.x_ent));
      chk({tag, " rd"}, rd, v.x_rd);
      chk({tag, " epc_out"}, epc_out, v.x_epc);
    end else begin
      chk({tag, " int_req"}, 32'(int_req), 32'(m_int()));
      chk({tag, " exc_enter"}, 32'(exc_enter), 32'(m_int() | v.ev));
      chk({tag, " rd"}, rd, m_rd(v.sel));
      chk({tag, " epc_out"}, epc_out, m_epc);
    end
    model_next(v);
    @(posedge clk);
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    #1;
  endtask

  vec_t rv;
  logic [4:0] codes[5];

  initial begin
    codes = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
    //           we sel  wd            hw     pc            bd ev code eret | int ent rd            epc
    tbl[0]  = mk(1, 12, 32'h401,       6'd0, 32'h0,        0, 0, 0,  0,   0, 0, 32'h0,        32'h0);
    tbl[1]  = mk(0, 13, 32'h0,         6'd1, 32'h0,        0, 0, 0,  0,   0, 0, 32'h0,        32'h0);
    tbl[2]  = mk(0, 13, 32'h0,         6'd1, 32'h3010,     0, 0, 0,  0,   1, 1, 32'h400,      32'h0);
    tbl[3]  = mk(0, 14, 32'h0,         6'd1, 32'h0,        0, 0, 0,  0,   0, 0, 32'h3010,     32'h3010);
    tbl[4]  = mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 0,  0,   0, 0, 32'h403,      32'h3010);
    tbl[5]  = mk(0, 13, 32'h0,         6'd1, 32'h0,        0, 0, 0,  1,   0, 0, 32'h400,      32'h3010);
    tbl[6]  = mk(0, 12, 32'h0,         6'd1, 32'h3000,     0, 0, 0,  0,   1, 1, 32'h401,      32'h3010);
    tbl[7]  = mk(0, 14, 32'h0,         6'd0, 32'h3024,     1, 1, 12, 0,   0, 1, 32'h3000,     32'h3000);
    tbl[8]  = mk(0, 13, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0,   0, 0, 32'h8000_0030, 32'h3020);
    tbl[9]  = mk(1, 13, 32'hFFFF_FFFF, 6'd0, 32'h0,        0, 0, 0,  0,   0, 0, 32'h8000_0030, 32'h3020);
    tbl[10] = mk(0, 13, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0,   0, 0, 32'h8000_0030, 32'h3020);
    tbl[11] = mk(0, 15, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0,   0, 0, PRID,         32'h3020);
    tbl[12] = mk(1, 3,  32'h123,       6'd0, 32'h0,        0, 0, 0,  0,   0, 0, 32'h0,        32'h3020);
    tbl[13] = mk(0, 3,  32'h0,         6'd0, 32'h0,        0, 0, 0,  0,   0, 0, 32'h0,        32'h3020);
    tbl[14] = mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 0,  1,   0, 0, 32'h403,      32'h3020);
    tbl[15] = mk(0, 12, 32'h0,         6'd1, 32'h4000,     0, 1, 10, 0,   1, 1, 32'h401,      32'h3020);
    tbl[16] = mk(0, 13, 32'h0,         6'd0, 32'h5008,     0, 1, 4,  1,   0, 1, 32'h400,      32'h4000);
    tbl[17] = mk(0, 12, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0,   0, 0, 32'h403,      32'h5008);
    tbl[18] = mk(0, 13, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0,   0, 0, 32'h10,       32'h5008);
    tbl[19] = mk(1, 14, 32'hDEAD_BEEF, 6'd0, 32'h6004,     0, 1, 5,  0,   0, 1, 32'h5008,     32'h5008);
    tbl[20] = mk(0, 14, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0,   0, 0, 32'h6004,     32'h6004);
    tbl[21] = mk(1, 14, 32'h1234_5677, 6'd0, 32'h0,        0, 0, 0,  0,   0, 0, 32'h6004,     32'h6004);
    tbl[22] = mk(0, 14, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0,   0, 0, 32'h1234_5674, 32'h1234_5674);
    tbl[23] = mk(1, 12, 32'h0,         6'd0, 32'h7000,     0, 1, 12, 0,   0, 1, 32'h403,      32'h1234_5674);
    tbl[24] = mk(0, 12, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0,   0, 0, 32'h2,        32'h7000);

    // Power-on reset
    reset = 1'b1;
    drive(mk(0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    m_sr = '0; m_cause = '0; m_epc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 25; i++) run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Async reset while in handler, with an interrupt line pending
    drive(mk(0, 12, 0, 6'd4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1 reset = 1'b1;
    sel = 5'd12;
    #1 chk("async SR", rd, 32'h0);
    sel = 5'd13;
    #1 chk("async Cause", rd, 32'h0);
    sel = 5'd14;
    #1 chk("async EPC", rd, 32'h0);
    chk("async epc_out", epc_out, 32'h0);
    chk("async int_req", 32'(int_req), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    sel = 5'd13;
    @(negedge clk);
    chk("post-release IP", rd, 32'h0);
    chk("post-release enter", 32'(exc_enter), 32'h0);
    @(negedge clk);
    chk("IP after release", rd, 32'h0000_1000);
    m_sr = '0; m_cause = 32'h0000_1000; m_epc = '0;
    @(posedge clk);
    #1;

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: rv.sel = 5'd12;
        1: rv.sel = 5'd13;
        2: rv.sel = 5'd14;
        3: rv.sel = 5'd15;
        default: rv.sel = 5'($urandom_range(0, 31));
      endcase
      rv.wd = $urandom;
      if (rv.sel == 5'd12) begin
        rv.wd[0] = ($urandom_range(0, 3) != 0);
        rv.wd[1] = ($urandom_range(0, 7) == 0);
      end
      rv.hw = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      rv.pc = $urandom;
      rv.bd = 1'($urandom_range(0, 1));
      rv.ev = ($urandom_range(0, 9) == 0);
      rv.code = codes[$urandom_range(0, 4)];
      rv.eret = ($urandom_range(0, 5) == 0);
      run_cycle(rv, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
